// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM states, fault cause codes and AXI response constants for the fetch unit
package ifu_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DELIVER, ERR} ifu_state_e;
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS      = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b11;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
endpackage

// File: rtl/ifu_pc_q.sv
// ifu_pc_q: fetch PC register with reset load, redirect select and +4 step
module ifu_pc_q #(
  parameter logic [31:0] RST_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] load_addr,
  output logic [31:0] pc
);
  // redirect beats sequential advance; +4 wraps naturally at 2**32
  always_ff @(posedge clk)
    pc <= rst ? RST_ADDR : load ? load_addr : inc ? pc + 32'd4 : pc;
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: PC sequencing and single-outstanding instruction fetch; IFU_MISALIGN_CHK_EN faults misaligned redirects
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RST_ADDR  = 32'h8000_0000,
  parameter int          TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        ifu_arvalid,
  output logic [31:0] ifu_araddr,
  input  logic        ifu_arready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  output logic        ifu_rready,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] current_pc,
  output logic        fetch_err,
  output logic [1:0]  err_cause
);
  ifu_state_e           state;
  logic                 pend_valid;
  logic [31:0]          pend_addr;
  logic [TIMEOUT_W-1:0] wd;
  logic [31:0]          redir_fix;
  logic [31:0]          tgt;
  logic                 mis;
  logic                 pc_load;
  logic                 pc_inc;
  logic                 squash;
`ifdef IFU_MISALIGN_CHK_EN
  assign redir_fix = redirect_addr;
  assign mis       = redirect_valid && (redirect_addr[1:0] != 2'b00) && state != ERR;
`else
  assign redir_fix = redirect_addr & ~32'd3;
  assign mis       = 1'b0;
`endif
  assign squash  = pend_valid || redirect_valid;
  assign tgt     = redirect_valid ? redir_fix : pend_addr;
  assign pc_load = !mis && ((redirect_valid && (state == IDLE || state == DELIVER)) ||
                            (state == WAIT && ifu_rvalid && squash));
  assign pc_inc  = state == DELIVER && inst_ready && !redirect_valid;
  assign ifu_araddr = current_pc;
  ifu_pc_q #(.RST_ADDR(RST_ADDR)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (tgt),
    .pc        (current_pc)
  );
  // fetch sequencer; all handshake outputs are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ifu_arvalid <= 1'b0;
      ifu_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      fetch_err   <= 1'b0;
      err_cause   <= CAUSE_NONE;
      inst        <= '0;
      inst_pc     <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      wd          <= '0;
    end else if (mis) begin
      state       <= ERR;
      ifu_arvalid <= 1'b0;
      ifu_rready  <= 1'b0;
      inst_valid  <= 1'b0;
      fetch_err   <= 1'b1;
      err_cause   <= CAUSE_MISALIGN;
    end else begin
      case (state)
        IDLE: begin
          state       <= REQ;
          ifu_arvalid <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) begin
            pend_valid <= 1'b1;
            pend_addr  <= redir_fix;
          end
          if (ifu_arready) begin
            state       <= WAIT;
            ifu_arvalid <= 1'b0;
            ifu_rready  <= 1'b1;
            wd          <= '0;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pend_valid <= 1'b1;
            pend_addr  <= redir_fix;
          end
          if (ifu_rvalid) begin
            ifu_rready <= 1'b0;
            pend_valid <= 1'b0;
            if (squash) begin
              state       <= REQ;
              ifu_arvalid <= 1'b1;
            end else if (ifu_rresp != RESP_OKAY) begin
              state     <= ERR;
              fetch_err <= 1'b1;
              err_cause <= CAUSE_BUS;
            end else begin
              state      <= DELIVER;
              inst_valid <= 1'b1;
              inst       <= ifu_rdata;
              inst_pc    <= current_pc;
            end
          end else if (wd == TIMEOUT_W'((2 ** TIMEOUT_W) - 2)) begin
            state      <= ERR;
            ifu_rready <= 1'b0;
            fetch_err  <= 1'b1;
            err_cause  <= CAUSE_TIMEOUT;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DELIVER: begin
          if (redirect_valid || inst_ready) begin
            state       <= REQ;
            ifu_arvalid <= 1'b1;
            inst_valid  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: table-driven fetch stream with scoreboard plus redirect, fault and timeout sequences
module tb_ifu_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready = 1'b0;
  logic        ifu_rvalid = 1'b0;
  logic [31:0] ifu_rdata = '0;
  logic [1:0]  ifu_rresp = '0;
  logic        ifu_rready;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] current_pc;
  logic        fetch_err;
  logic [1:0]  err_cause;

  typedef struct {
    int          lat;
    int          rdy_dly;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .ifu_arvalid    (ifu_arvalid),
    .ifu_araddr     (ifu_araddr),
    .ifu_arready    (ifu_arready),
    .ifu_rvalid     (ifu_rvalid),
    .ifu_rdata      (ifu_rdata),
    .ifu_rresp      (ifu_rresp),
    .ifu_rready     (ifu_rready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .current_pc     (current_pc),
    .fetch_err      (fetch_err),
    .err_cause      (err_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rresp = '0;
    inst_ready = 1'b0;
    sb.delete();
    repeat (3) tick();
    chk("rst_pc", current_pc, 32'h8000_0000);
    chk("rst_arvalid", 32'(ifu_arvalid), 0);
    chk("rst_rready", 32'(ifu_rready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    chk("rst_err_cause", 32'(err_cause), 0);
    chk("rst_inst_pc", inst_pc, 0);
    rst = 1'b0;
  endtask

  task automatic do_ar(input string name, input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifu_arvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_arvalid"}, 32'(ok), 1);
    chk({name, "_araddr"}, ifu_araddr, a);
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
  endtask

  task automatic do_r(input int lat, input logic [31:0] d, input logic [1:0] resp,
                      input logic [31:0] pc, input bit push);
    repeat (lat) tick();
    chk("rready", 32'(ifu_rready), 1);
    ifu_rvalid = 1'b1;
    ifu_rdata = d;
    ifu_rresp = resp;
    if (push) sb.push_back('{pc: pc, ins: d});
    tick();
    ifu_rvalid = 1'b0;
    ifu_rresp = '0;
  endtask

  task automatic deliver(input int dly, input bit rdy, input bit redir, input logic [31:0] tgt);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("inst_valid_seen", 32'(ok), 1);
    chk("scoreboard_has_entry", 32'(sb.size()), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.ins);
      chk("inst_pc", inst_pc, e.pc);
    end
    repeat (dly) tick();
    chk("inst_valid_held", 32'(inst_valid), 1);
    inst_ready = rdy;
    redirect_valid = redir;
    redirect_addr = tgt;
    tick();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("inst_valid_drop", 32'(inst_valid), 0);
  endtask

  initial begin
    bit seen_iv;
    vecs[0] = '{lat: 2, rdy_dly: 0, addr: 32'h8000_0000, data: 32'h0000_0413};
    vecs[1] = '{lat: 0, rdy_dly: 2, addr: 32'h8000_0004, data: 32'h0010_0093};
    vecs[2] = '{lat: 1, rdy_dly: 0, addr: 32'h8000_0008, data: 32'hFFF0_0113};
    vecs[3] = '{lat: 3, rdy_dly: 1, addr: 32'h8000_000C, data: 32'h0020_8233};
    vecs[4] = '{lat: 0, rdy_dly: 0, addr: 32'h8000_0010, data: 32'hA5A5_5A5A};
    tick();
    do_reset();

    // sequential stream
    for (int i = 0; i < 5; i++) begin
      do_ar("stream", vecs[i].addr);
      do_r(vecs[i].lat, vecs[i].data, 2'b00, vecs[i].addr, 1'b1);
      deliver(vecs[i].rdy_dly, 1'b1, 1'b0, '0);
    end

    // redirect during WAIT discards in-flight data
    do_ar("pre_flush", 32'h8000_0014);
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    do_r(1, 32'hDEAD_BEEF, 2'b00, '0, 1'b0);
    seen_iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen_iv |= inst_valid;
      if (!ifu_arvalid) tick();
    end
    chk("no_stale_inst", 32'(seen_iv), 0);
    do_ar("flush_target", 32'h8000_0100);
    do_r(0, 32'h1111_0013, 2'b00, 32'h8000_0100, 1'b1);

    // redirect and inst_ready together: redirect wins
    deliver(0, 1'b1, 1'b1, 32'h8000_0200);
    chk("sb_empty_after_flush", 32'(sb.size()), 0);

    // redirect in REQ is pended, address held; later redirect in WAIT overwrites it
    for (int i = 0; i < 4 && !ifu_arvalid; i++) tick();
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("req_arvalid_held", 32'(ifu_arvalid), 1);
    chk("req_araddr_held", ifu_araddr, 32'h8000_0200);
    do_ar("pend_req", 32'h8000_0200);
    redirect_valid = 1'b1;
    redirect_addr = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    do_r(0, 32'hBAD0_BAD0, 2'b00, '0, 1'b0);
    do_ar("pend_overwrite", 32'h8000_0400);
    do_r(1, 32'h2222_0013, 2'b00, 32'h8000_0400, 1'b1);

    // redirect in DELIVER without ready, then PC wrap
    deliver(1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    do_ar("wrap_top", 32'hFFFF_FFFC);
    do_r(0, 32'h0010_0073, 2'b00, 32'hFFFF_FFFC, 1'b1);
    deliver(0, 1'b1, 1'b0, '0);
    chk("wrap_no_err", 32'(fetch_err), 0);
    do_ar("wrap_zero", 32'h0000_0000);
    do_r(0, 32'h0000_0013, 2'b00, 32'h0000_0000, 1'b1);

    // misaligned redirect
    deliver(0, 1'b0, 1'b1, 32'h8000_0102);
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_fetch_err", 32'(fetch_err), 1);
    chk("mis_err_cause", 32'(err_cause), 3);
    tick();
    chk("mis_no_arvalid", 32'(ifu_arvalid), 0);
`else
    chk("mis_no_err", 32'(fetch_err), 0);
    do_ar("mis_forced", 32'h8000_0100);
`endif

    // bus error is sticky and stops fetching
    do_reset();
    do_ar("bus_err", 32'h8000_0000);
    do_r(1, 32'h0000_0413, 2'b10, '0, 1'b0);
    chk("bus_fetch_err", 32'(fetch_err), 1);
    chk("bus_err_cause", 32'(err_cause), 1);
    seen_iv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_iv |= ifu_arvalid | inst_valid;
      tick();
    end
    chk("bus_err_quiet", 32'(seen_iv), 0);
    chk("bus_err_sticky", 32'(fetch_err), 1);

    // watchdog timeout
    do_reset();
    do_ar("timeout", 32'h8000_0000);
    repeat (250) tick();
    chk("timeout_not_early", 32'(fetch_err), 0);
    for (int i = 0; i < 10 && !fetch_err; i++) tick();
    chk("timeout_fetch_err", 32'(fetch_err), 1);
    chk("timeout_err_cause", 32'(err_cause), 2);
    chk("timeout_rready_low", 32'(ifu_rready), 0);
    do_reset();
    do_ar("after_timeout", 32'h8000_0000);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
